// File: rtl/path_pkg.sv
// Shared types and constants for the heap path sift sequencer.
// Entry layout: [64]=valid, [63:32]=key, [31:0]=payload.
package path_pkg;

   localparam int DEPTH     = 1000;
   localparam int AW        = 16;
   localparam int KW        = 32;
   localparam int DW        = 65;

   localparam int VALID_BIT = 64;
   localparam int KEY_MSB   = 63;
   localparam int KEY_LSB   = 32;

   typedef struct packed {
      logic          v;
      logic [KW-1:0] k;
   } vk_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_CUR,
      ST_RD_P,
      ST_RD_L,
      ST_RD_R,
      ST_CMP,
      ST_WR_1,
      ST_WR_2,
      ST_DONE
   } state_e;

   // An invalid entry behaves as key +infinity; ties are never "less".
   function automatic logic key_less(input vk_t a, input vk_t b);
      return a.v && (!b.v || (a.k < b.k));
   endfunction

endpackage

// File: rtl/path_key_cmp.sv
// Picks the lesser of two candidates (a, optional b) and flags a swap
// when that candidate is strictly less than the reference entry.
module path_key_cmp
   import path_pkg::*;
(
   input  vk_t  ref_vk_i,
   input  vk_t  a_vk_i,
   input  vk_t  b_vk_i,
   input  logic b_ok_i,
   output logic sel_b_o,
   output logic swap_o
);

   vk_t child;

   assign sel_b_o = b_ok_i && key_less(b_vk_i, a_vk_i);
   assign child   = sel_b_o ? b_vk_i : a_vk_i;
   assign swap_o  = key_less(child, ref_vk_i);

endmodule

// File: rtl/path_sift_ctrl.sv
// Multi-cycle sift-up / sift-down sequencer over a 1R/1W path RAM.
// Optional swap counter enabled by defining PATH_SIFT_STATS_EN.
module path_sift_ctrl
   import path_pkg::*;
(
   input  logic          system1000,
   input  logic          system1000_rstn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_idx,
   input  logic [AW-1:0] heap_size,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          done,
   output logic [AW-1:0] done_idx,
   output logic          done_err,
   output logic [31:0]   stat_swaps
);

   state_e        state_q, state_d;
   logic          op_q, op_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] size_q, size_d;
   logic [AW-1:0] nidx_q, nidx_d;
   logic          first_q, first_d;
   logic          err_q, err_d;
   logic          has_r_q, has_r_d;
   logic [DW-1:0] cur_q, cur_d;
   logic [DW-1:0] l_q, l_d;
   logic [DW-1:0] nb_q, nb_d;

   logic [AW:0]   l_w, r_w, size_w;
   logic [AW-1:0] p_w;
   vk_t           rd_vk, cur_vk, l_vk;
   vk_t           cmp_ref, cmp_a;
   logic          cmp_b_ok, sel_b, do_swap;

   // Child indices are AW+1 bits wide so 2*idx+2 cannot wrap.
   assign l_w    = {idx_q, 1'b1};
   assign r_w    = l_w + (AW+1)'(1);
   assign size_w = {1'b0, size_q};
   assign p_w    = (idx_q - AW'(1)) >> 1;

   assign rd_vk  = {rd_data[VALID_BIT], rd_data[KEY_MSB:KEY_LSB]};
   assign cur_vk = {cur_q[VALID_BIT], cur_q[KEY_MSB:KEY_LSB]};
   assign l_vk   = {l_q[VALID_BIT], l_q[KEY_MSB:KEY_LSB]};

   // Up: cur vs parent (on rd_data). Down: min(L, R) vs cur.
   assign cmp_ref  = op_q ? cur_vk : rd_vk;
   assign cmp_a    = op_q ? l_vk : cur_vk;
   assign cmp_b_ok = op_q & has_r_q;

   path_key_cmp u_cmp (
      .ref_vk_i (cmp_ref),
      .a_vk_i   (cmp_a),
      .b_vk_i   (rd_vk),
      .b_ok_i   (cmp_b_ok),
      .sel_b_o  (sel_b),
      .swap_o   (do_swap)
   );

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         state_q <= ST_IDLE;
         op_q    <= 1'b0;
         idx_q   <= '0;
         size_q  <= '0;
         nidx_q  <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
         has_r_q <= 1'b0;
         cur_q   <= '0;
         l_q     <= '0;
         nb_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         size_q  <= size_d;
         nidx_q  <= nidx_d;
         first_q <= first_d;
         err_q   <= err_d;
         has_r_q <= has_r_d;
         cur_q   <= cur_d;
         l_q     <= l_d;
         nb_q    <= nb_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      size_d    = size_q;
      nidx_d    = nidx_q;
      first_d   = first_q;
      err_d     = err_q;
      has_r_d   = has_r_q;
      cur_d     = cur_q;
      l_d       = l_q;
      nb_d      = nb_q;
      cmd_ready = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      done      = 1'b0;
      done_idx  = '0;
      done_err  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               idx_d   = cmd_idx;
               size_d  = heap_size;
               first_d = 1'b1;
               err_d   = (cmd_idx >= heap_size);
               state_d = (cmd_idx >= heap_size) ? ST_DONE : ST_RD_CUR;
            end
         end
         ST_RD_CUR: begin
            rd_en   = 1'b1;
            rd_addr = idx_q;
            state_d = op_q ? ST_RD_L : ST_RD_P;
         end
         ST_RD_P: begin
            if (first_q) begin
               cur_d   = rd_data;
               first_d = 1'b0;
            end
            if (idx_q == '0) begin
               state_d = ST_DONE;
            end else begin
               rd_en   = 1'b1;
               rd_addr = p_w;
               nidx_d  = p_w;
               state_d = ST_CMP;
            end
         end
         ST_RD_L: begin
            if (first_q) begin
               cur_d   = rd_data;
               first_d = 1'b0;
            end
            if (l_w >= size_w) begin
               state_d = ST_DONE;
            end else begin
               rd_en   = 1'b1;
               rd_addr = l_w[AW-1:0];
               state_d = ST_RD_R;
            end
         end
         ST_RD_R: begin
            l_d     = rd_data;
            nidx_d  = l_w[AW-1:0];
            has_r_d = (r_w < size_w);
            if (r_w < size_w) begin
               rd_en   = 1'b1;
               rd_addr = r_w[AW-1:0];
            end
            state_d = ST_CMP;
         end
         ST_CMP: begin
            if (!op_q) begin
               nb_d = rd_data;
            end else if (sel_b) begin
               nb_d   = rd_data;
               nidx_d = r_w[AW-1:0];
            end else begin
               nb_d = l_q;
            end
            state_d = do_swap ? ST_WR_1 : ST_DONE;
         end
         ST_WR_1: begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = nb_q;
            state_d = ST_WR_2;
         end
         ST_WR_2: begin
            wr_en   = 1'b1;
            wr_addr = nidx_q;
            wr_data = cur_q;
            idx_d   = nidx_q;
            state_d = op_q ? ST_RD_L : ST_RD_P;
         end
         ST_DONE: begin
            done     = 1'b1;
            done_idx = idx_q;
            done_err = err_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef PATH_SIFT_STATS_EN
   logic [31:0] stat_q;

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         stat_q <= '0;
      end else if (state_q == ST_WR_2) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign stat_swaps = stat_q;
`else
   assign stat_swaps = '0;
`endif

endmodule

// File: tb/tb_path_sift_ctrl.sv
// Directed bench for path_sift_ctrl with a bench-side RAM and a
// reference heap model computing final contents, index and latency.
module tb_path_sift_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [15:0] cmd_idx;
   logic [15:0] heap_size;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [64:0] rd_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [64:0] wr_data;
   logic        done;
   logic [15:0] done_idx;
   logic        done_err;
   logic [31:0] stat_swaps;

   path_sift_ctrl dut (
      .system1000      (clk),
      .system1000_rstn (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_idx         (cmd_idx),
      .heap_size       (heap_size),
      .rd_en           (rd_en),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .done            (done),
      .done_idx        (done_idx),
      .done_err        (done_err),
      .stat_swaps      (stat_swaps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [64:0] mem [16];
   logic [64:0] img [16];
   logic        load_en;
   int          cyc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load_en) begin
         for (int i = 0; i < 16; i++) mem[i] <= img[i];
      end else begin
         if (rd_en) rd_data <= mem[rd_addr[3:0]];
         if (wr_en) mem[wr_addr[3:0]] <= wr_data;
      end
   end

   int n_cmp, n_fail;
   int n_rd, n_wr, n_acc;
   bit busy;
   int acc_cyc;
   int last_idx, last_err, last_lat;

   logic [64:0] exp_mem [16];
   int exp_idx, exp_swaps, exp_lat, exp_err;
   int exp_stat;

   task chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [64:0] mk(input bit v, input int k, input int p);
      return {v, k[31:0], p[31:0]};
   endfunction

   function automatic bit lt(input logic [64:0] a, input logic [64:0] b);
      if (!a[64]) return 1'b0;
      if (!b[64]) return 1'b1;
      return a[63:32] < b[63:32];
   endfunction

   // Reference heap: operate on a copy of the image with array indices.
   task model(input bit op, input int idx, input int size);
      int i, p, l, c;
      logic [64:0] t;
      for (int k = 0; k < 16; k++) exp_mem[k] = img[k];
      exp_swaps = 0;
      exp_err   = 0;
      i = idx;
      if (idx >= size) begin
         exp_err = 1;
         exp_lat = 1;
      end else if (!op) begin
         forever begin
            if (i == 0) begin
               exp_lat = 3 + 4 * exp_swaps;
               break;
            end
            p = (i - 1) / 2;
            if (lt(exp_mem[i], exp_mem[p])) begin
               t = exp_mem[i]; exp_mem[i] = exp_mem[p]; exp_mem[p] = t;
               i = p;
               exp_swaps++;
            end else begin
               exp_lat = 4 + 4 * exp_swaps;
               break;
            end
         end
      end else begin
         forever begin
            l = 2 * i + 1;
            if (l >= size) begin
               exp_lat = 3 + 5 * exp_swaps;
               break;
            end
            c = l;
            if (l + 1 < size && lt(exp_mem[l+1], exp_mem[l])) c = l + 1;
            if (lt(exp_mem[c], exp_mem[i])) begin
               t = exp_mem[i]; exp_mem[i] = exp_mem[c]; exp_mem[c] = t;
               i = c;
               exp_swaps++;
            end else begin
               exp_lat = 5 + 5 * exp_swaps;
               break;
            end
         end
      end
      exp_idx = i;
   endtask

   task mon_step();
      if (!rst_n) begin
         busy = 1'b0;
         return;
      end
      chk("port_excl", {94'd0, rd_en, wr_en} & 96'd3, (rd_en & wr_en) ? 96'd1 : {94'd0, rd_en, wr_en});
      if (rd_en) n_rd++;
      if (wr_en) n_wr++;
      if (busy) chk("ready_busy", cmd_ready, 0);
      if (done) begin
         chk("done_when_busy", busy, 1);
         chk("done_idx", done_idx, exp_idx);
         chk("done_err", done_err, exp_err);
         chk("latency", cyc - acc_cyc, exp_lat);
         chk("stat_swaps", stat_swaps, exp_stat);
         last_idx = done_idx;
         last_err = done_err;
         last_lat = cyc - acc_cyc;
         busy = 1'b0;
      end else if (!busy && cmd_valid && cmd_ready) begin
         busy    = 1'b1;
         acc_cyc = cyc;
         n_acc++;
      end
   endtask

   task load();
      @(posedge clk); #1;
      load_en = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   task clear_img();
      for (int k = 0; k < 16; k++) img[k] = mk(1'b0, 0, 32'h100 + k);
   endtask

   task run_cmd(input bit op, input int idx, input int size, input bit hold);
      int rd0, wr0, ac0, t;
      model(op, idx, size);
`ifdef PATH_SIFT_STATS_EN
      exp_stat += exp_swaps;
`endif
      rd0 = n_rd; wr0 = n_wr; ac0 = n_acc;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = idx[15:0];
      heap_size = size[15:0];
      if (!hold) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         heap_size = '0;
      end
      t = 0;
      while (!done && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_seen", done, 1);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("accept_once", n_acc - ac0, 1);
      chk("write_count", n_wr - wr0, 2 * exp_swaps);
      if (exp_err != 0) chk("err_no_reads", n_rd - rd0, 0);
      for (int k = 0; k < 16; k++) chk($sformatf("mem[%0d]", k), mem[k], exp_mem[k]);
   endtask

   initial begin
      int t;
      n_cmp = 0; n_fail = 0; n_rd = 0; n_wr = 0; n_acc = 0;
      busy = 1'b0; acc_cyc = 0; exp_stat = 0; cyc = 0;
      last_idx = -1; last_err = -1; last_lat = -1;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
      cmd_idx = '0; heap_size = '0; load_en = 1'b0; rd_data = '0;
      clear_img();
      exp_idx = 0; exp_err = 0; exp_lat = 0; exp_swaps = 0;
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_done", {done, done_err}, 0);
      chk("rst_addr", {rd_addr, wr_addr, done_idx}, 0);
      chk("rst_wdata", wr_data, 0);
      chk("rst_stat", stat_swaps, 0);
      @(negedge clk); rst_n = 1'b1;

      // sift-up chain
      clear_img();
      img[0] = mk(1, 10, 0); img[1] = mk(1, 20, 1);
      img[2] = mk(1, 30, 2); img[3] = mk(1, 5, 3);
      load();
      run_cmd(1'b0, 3, 4, 1'b0);
      chk("t1_k0", mem[0][63:32], 5);
      chk("t1_k1", mem[1][63:32], 10);
      chk("t1_k2", mem[2][63:32], 30);
      chk("t1_k3", mem[3][63:32], 20);
      chk("t1_idx", last_idx, 0);
      chk("t1_lat", last_lat, 11);

      // sift-up from root
      load();
      run_cmd(1'b0, 0, 4, 1'b0);
      chk("root_lat", last_lat, 3);

      // equal key, no swap
      img[3] = mk(1, 20, 3);
      load();
      run_cmd(1'b0, 3, 4, 1'b0);
      chk("tie_idx", last_idx, 3);

      // sift-down, cmd_valid held while busy
      clear_img();
      img[0] = mk(1, 50, 0); img[1] = mk(1, 20, 1); img[2] = mk(1, 10, 2);
      img[3] = mk(1, 30, 3); img[4] = mk(1, 40, 4);
      load();
      run_cmd(1'b1, 0, 5, 1'b1);
      chk("t5_idx", last_idx, 2);
      chk("t5_k0", mem[0][63:32], 10);
      chk("t5_k2", mem[2][63:32], 50);
      chk("t5_lat", last_lat, 8);

      // sift-down two levels, tied children prefer left
      clear_img();
      img[0] = mk(1, 30, 0); img[1] = mk(1, 10, 1); img[2] = mk(1, 10, 2);
      img[3] = mk(1, 15, 3); img[4] = mk(1, 16, 4); img[5] = mk(1, 17, 5);
      img[6] = mk(1, 18, 6);
      load();
      run_cmd(1'b1, 0, 7, 1'b0);
      chk("t6_idx", last_idx, 3);
      chk("t6_p0", mem[0][31:0], 1);
      chk("t6_lat", last_lat, 13);

      // single child with valid=0
      clear_img();
      img[0] = mk(1, 50, 0); img[1] = mk(0, 1, 1);
      load();
      run_cmd(1'b1, 0, 2, 1'b0);
      chk("inv_idx", last_idx, 0);

      // rejected command
      run_cmd(1'b0, 7, 7, 1'b0);
      chk("err_flag", last_err, 1);
      chk("err_idx", last_idx, 7);

      // reset during WR_1
      clear_img();
      img[0] = mk(1, 10, 0); img[1] = mk(1, 20, 1);
      img[2] = mk(1, 30, 2); img[3] = mk(1, 5, 3);
      load();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_idx = 16'd3; heap_size = 16'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (!wr_en && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wr1_reached", wr_en, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_strobes", {rd_en, wr_en, done, done_err}, 0);
      chk("mid_rst_addr", {rd_addr, wr_addr, done_idx}, 0);
      chk("mid_rst_wdata", wr_data, 0);
      chk("mid_rst_stat", stat_swaps, 0);
      exp_stat = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", cmd_ready, 1);
      load();
      run_cmd(1'b0, 3, 4, 1'b0);
      chk("post_rst_idx", last_idx, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/path_sift_ctrl.md
Name: path_sift_ctrl

Overview:
- Sequencer for the heap "path" storage of the priority queue: executes one sift-up or sift-down per command as a chain of compare-and-swap steps on a single read port and a single write port.
- Sits between the queue front-end (insert/pop logic) and the path RAM; replaces wide combinational whole-vector swaps with a multi-cycle swap sequence.
- Min-heap ordering; one command in flight.

Parameters:
- DEPTH, 1000, number of path entries
- AW, 16, index/address width
- KW, 32, key width
- DW, 65, entry width: [64]=valid, [63:32]=key, [31:0]=payload

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0=sift-up, 1=sift-down
- cmd_idx  in  AW  starting index
- heap_size  in  AW  live entry count; sampled at command accept
- rd_en  out  1  read strobe
- rd_addr  out  AW  read address
- rd_data  in  DW  read data, valid exactly one cycle after rd_en
- wr_en  out  1  write strobe
- wr_addr  out  AW  write address
- wr_data  out  DW  write data
- done  out  1  one-cycle pulse at end of command
- done_idx  out  AW  final resting index of the moved entry
- done_err  out  1  command rejected (cmd_idx >= heap_size)
- stat_swaps  out  32  cumulative swap count (optional feature)

Behaviour:
- Reset: state=IDLE; cmd_ready=1; rd_en, wr_en, done, done_err=0; all address/data/done_idx outputs and stat_swaps=0.
- Accept on cmd_valid&&cmd_ready. Latch op, idx, and size from heap_size.
- Ordering rule: an entry with valid=0 has key +infinity. Swap only when the child key is strictly less than the parent key; ties never swap.
- States: IDLE, RD_CUR, RD_P, RD_L, RD_R, CMP, WR_1, WR_2, DONE.
- IDLE, accept:
  - if idx>=size: go to DONE with done_err=1, done_idx=idx.
  - else: go to RD_CUR.
- RD_CUR: rd_en=1, rd_addr=idx. Next state is RD_P (up) or RD_L (down).
- Sift-up:
  - RD_P: capture cur=rd_data. If idx==0, go to DONE. Else rd parent p=(idx-1)>>1 and go to CMP.
  - CMP: if key(cur) < key(parent), go to WR_1; else go to DONE.
  - WR_1: write parent entry to idx.
  - WR_2: write cur to p; set idx=p; then go to RD_P. RD_P skips the cur capture after the first pass, because cur is held in a register and never re-read.
- Sift-down:
  - RD_L: capture cur on the first pass. Let l=2*idx+1 and r=l+1, computed at AW+1 bits so there is no wrap. If l>=size, go to DONE. Else rd l.
  - RD_R: capture L. If r<size, rd r. Go to CMP.
  - CMP: capture R if it was read. Child c = R if key(R)<key(L), else L. If key(c)<key(cur), go to WR_1; else go to DONE.
  - WR_1: write child to idx.
  - WR_2: write cur to c; set idx=c; go to RD_L.
- DONE: done=1 for one cycle with done_idx=idx; then go to IDLE (cmd_ready=1 the following cycle).
- Port usage: rd_en and wr_en are never high in the same cycle. Each swap is exactly two writes, in consecutive cycles.
- Latency:
  - sift-up from idx 0: done 3 cycles after accept.
  - each sift-up swap level: 4 cycles (RD_P, CMP, WR_1, WR_2).
  - sift-down level: 5 cycles.
- heap_size changes mid-command are ignored.
- Reset mid-command: returns to IDLE immediately. A swap cut between WR_1 and WR_2 leaves a duplicated entry; the front-end must treat the path as invalid after reset.

Optional Feature:
- PATH_SIFT_STATS_EN defined: stat_swaps increments by 1 on every WR_2 and wraps at 2^32. It is cleared only by reset.
- Undefined: stat_swaps is tied to 0 and the counter is not built.

Decomposition:
- Shared package path_pkg:
  - DW, KW, AW, DEPTH constants
  - entry field offsets (VALID_BIT, KEY_MSB/LSB)
  - state enum encoding
  - key_less function implementing the invalid-as-infinity rule
- One natural sub-module, path_key_cmp: combinational 3-way compare. Picks the lesser child and flags swap; shared by both directions.

Test Plan:
- Sift-up chain: size=4, keys [10,20,30,5] at 0..3, up from idx 3 -> swaps 3<->1 then 1<->0; final keys [5,10,30,20]; done_idx=0; swap count +2.
- Sift-up no-move / root:
  - idx 0 -> done 3 cycles after accept, no wr_en.
  - key equal to parent -> no swap.
- Sift-down with children: size=5, keys [50,20,10,30,40], down from 0 -> swap with idx 2 (key 10); l=5>=size stops; done_idx=2.
- Single-child and invalid: size=2, down from 0 with child 1 valid=0 -> no swap, done_idx=0.
- Error and handshake:
  - cmd_idx=7 with size=7 -> done=1, done_err=1, no memory access.
  - cmd_valid held during busy -> cmd_ready=0, no second accept until after done.
- Reset mid-swap: assert system1000_rstn=0 in WR_1 -> all outputs reset values next cycle; state IDLE; cmd_ready=1 after release.
